// File: rtl/dmem_lsu.sv
// Load/store unit between the CPU data port and a 32-bit word-wide data memory.
// Latency: an accepted access spends one ACCESS cycle, then one RESP cycle; an error goes straight to RESP.
// Backpressure: req_ready is high only in IDLE; the response is held until rsp_ready.
//
// Ports:
//   clock, resetn           clock and asynchronous active-low reset
//   req_*                   byte-addressed request (valid/ready), size, signedness, store data
//   rsp_*                   response (valid/ready), extended load data, error flag
//   mem_*                   memory side: word addresses, lane-shifted data, byte enables, write enable, read data
module dmem_lsu #(
  parameter int unsigned ADDR_W    = 15,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_rdaddress,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic [31:0]       mem_data,
  output logic [3:0]        mem_byteena,
  output logic              mem_wren,
  input  logic [31:0]       mem_q
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size of the mapped window in bytes.
  localparam logic [31:0] MEM_BYTES = 32'd4 << ADDR_W;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_we;
  logic [1:0]          r_addr_lo;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [31:0]         r_wdata;
  logic [ADDR_W-1:0]   r_word;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;

  logic [31:0]         w_off;
  logic                w_err;
  logic                w_accept;
  logic [3:0]          w_store_be;
  logic [31:0]         w_store_data;
  logic [7:0]          w_ld_byte;
  logic [15:0]         w_ld_half;
  logic [31:0]         w_ld_ext;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
  assign w_off = req_addr - BASE_ADDR;

  assign w_err = (req_size == 2'b11)
              || ((req_size == SZ_HALF) && req_addr[0])
              || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
              || (w_off >= MEM_BYTES);

  assign w_accept = req_valid && req_ready;

  // FSM: state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state and control outputs
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_wren    = 1'b0;
    mem_byteena = 4'b0000;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = w_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_RESP;
        if (r_we) begin
          mem_wren    = 1'b1;
          mem_byteena = w_store_be;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Store lane placement: data is replicated so the byte enables alone pick the lane.
  always_comb begin
    w_store_be   = 4'b1111;
    w_store_data = r_wdata;
    case (r_size)
      SZ_BYTE: begin
        w_store_be   = 4'b0001 << r_addr_lo;
        w_store_data = {4{r_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_store_be   = r_addr_lo[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_store_be   = 4'b1111;
        w_store_data = r_wdata;
      end
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    w_ld_byte = mem_q[7:0];
    case (r_addr_lo)
      2'd0:    w_ld_byte = mem_q[7:0];
      2'd1:    w_ld_byte = mem_q[15:8];
      2'd2:    w_ld_byte = mem_q[23:16];
      default: w_ld_byte = mem_q[31:24];
    endcase
    w_ld_half = r_addr_lo[1] ? mem_q[31:16] : mem_q[15:0];
    w_ld_ext  = mem_q;
    case (r_size)
      SZ_BYTE: w_ld_ext = {{24{w_ld_byte[7]  & ~r_unsigned}}, w_ld_byte};
      SZ_HALF: w_ld_ext = {{16{w_ld_half[15] & ~r_unsigned}}, w_ld_half};
      default: w_ld_ext = mem_q;
    endcase
  end

  // Request capture and response registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_we        <= 1'b0;
      r_addr_lo   <= 2'b00;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_wdata     <= 32'd0;
      r_word      <= '0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we        <= req_we;
        r_addr_lo   <= req_addr[1:0];
        r_size      <= req_size;
        r_unsigned  <= req_unsigned;
        r_wdata     <= req_wdata;
        r_word      <= w_off[ADDR_W+1:2];
        r_rsp_err   <= w_err;
        r_rsp_rdata <= 32'd0;
      end
      if (r_state == S_ACCESS) begin
        r_rsp_rdata <= r_we ? 32'd0 : w_ld_ext;
      end
      if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_rdata <= 32'd0;
        r_rsp_err   <= 1'b0;
      end
    end
  end

  assign mem_rdaddress = r_word;
  assign mem_wraddress = r_word;
  assign mem_data      = w_store_data;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_err       = r_rsp_err;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  logic        clock;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [14:0] mem_rdaddress;
  logic [14:0] mem_wraddress;
  logic [31:0] mem_data;
  logic [3:0]  mem_byteena;
  logic        mem_wren;
  logic [31:0] mem_q;

  int checks;
  int failures;

  logic [31:0] t_rdata;
  logic        t_err;
  logic        t_wren;
  logic [3:0]  t_be;
  int          t_lat;

  // Behavioural word memory with byte enables; read is combinational.
  logic [31:0] mem [0:32767];

  dmem_lsu #(.ADDR_W(15), .BASE_ADDR(32'h0001_0000)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_rdaddress(mem_rdaddress), .mem_wraddress(mem_wraddress), .mem_data(mem_data),
    .mem_byteena(mem_byteena), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byteena[b]) mem[mem_wraddress][8*b +: 8] <= mem_data[8*b +: 8];
      end
    end
  end

  assign mem_q = mem[mem_rdaddress];

  // One full transaction with rsp_ready asserted as soon as the response shows up.
  task automatic transact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata);
    int n;
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clock); n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", addr, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    t_wren = 1'b0; t_be = 4'b0000; t_lat = 0;
    while (!rsp_valid && t_lat < 20) begin
      if (mem_wren) begin t_wren = 1'b1; t_be = mem_byteena; end
      @(posedge clock); #1;
      t_lat++;
    end
    if (!rsp_valid) begin
      checks++; failures++;
      $display("FAIL rsp_timeout addr=%h rsp_valid=%b required 1", addr, rsp_valid);
      return;
    end
    t_rdata = rsp_rdata; t_err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (mem_wren !== 1'b0 || mem_byteena !== 4'b0000) begin failures++; $display("FAIL rst_mem_ctrl got wren=%b be=%b exp 0/0000", mem_wren, mem_byteena); end
    checks++; if (mem_data !== 32'd0 || mem_rdaddress !== 15'd0 || mem_wraddress !== 15'd0) begin failures++; $display("FAIL rst_mem_bus got data=%h ra=%h wa=%h exp 0", mem_data, mem_rdaddress, mem_wraddress); end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset_abort;
    transact(1'b1, 32'h0001_0014, 2'b10, 1'b0, 32'hDEAD_BEEF);
    checks++; if (mem[5] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL abort_preload got=%h exp=deadbeef", mem[5]); end
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0001_0014; req_size = 2'b10; req_wdata = 32'hCAFE_F00D;
    @(posedge clock); #1;
    req_valid = 1'b0;
    checks++; if (mem_wren !== 1'b1) begin failures++; $display("FAIL abort_in_access wren got=%b exp=1", mem_wren); end
    resetn = 1'b0;
    #2;
    checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL abort_wren_drop got=%b exp=0", mem_wren); end
    @(posedge clock); @(posedge clock); #1;
    checks++; if (mem[5] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL abort_mem_word got=%h exp=deadbeef", mem[5]); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL abort_rsp_valid got=%b exp=0", rsp_valid); end
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL abort_after_release req_ready=%b rsp_valid=%b exp 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_word;
    transact(1'b1, 32'h0001_0008, 2'b10, 1'b0, 32'h1122_3344);
    checks++; if (t_err !== 1'b0 || t_rdata !== 32'd0) begin failures++; $display("FAIL st_word_rsp err=%b rdata=%h exp 0/0", t_err, t_rdata); end
    checks++; if (t_wren !== 1'b1 || t_be !== 4'b1111) begin failures++; $display("FAIL st_word_be wren=%b be=%b exp 1/1111", t_wren, t_be); end
    checks++; if (t_lat !== 1) begin failures++; $display("FAIL st_word_latency got=%0d exp=1", t_lat); end
    checks++; if (mem[2] !== 32'h1122_3344) begin failures++; $display("FAIL st_word_mem got=%h exp=11223344", mem[2]); end
    transact(1'b0, 32'h0001_0008, 2'b10, 1'b0, 32'd0);
    checks++; if (t_rdata !== 32'h1122_3344 || t_err !== 1'b0) begin failures++; $display("FAIL ld_word rdata=%h err=%b exp 11223344/0", t_rdata, t_err); end
    checks++; if (t_wren !== 1'b0) begin failures++; $display("FAIL ld_word_wren got=%b exp=0", t_wren); end
  endtask

  task automatic test_subword;
    transact(1'b1, 32'h0001_0009, 2'b00, 1'b0, 32'hABCD_EF80);
    checks++; if (t_be !== 4'b0010 || t_wren !== 1'b1) begin failures++; $display("FAIL st_byte_be be=%b wren=%b exp 0010/1", t_be, t_wren); end
    transact(1'b0, 32'h0001_0009, 2'b00, 1'b0, 32'd0);
    checks++; if (t_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL ld_byte_signed got=%h exp=ffffff80", t_rdata); end
    transact(1'b0, 32'h0001_0009, 2'b00, 1'b1, 32'd0);
    checks++; if (t_rdata !== 32'h0000_0080) begin failures++; $display("FAIL ld_byte_unsigned got=%h exp=00000080", t_rdata); end
    transact(1'b0, 32'h0001_0008, 2'b10, 1'b0, 32'd0);
    checks++; if (t_rdata !== 32'h1122_8044) begin failures++; $display("FAIL ld_word_after_byte got=%h exp=11228044", t_rdata); end
    transact(1'b0, 32'h0001_0008, 2'b01, 1'b0, 32'd0);
    checks++; if (t_rdata !== 32'hFFFF_8044) begin failures++; $display("FAIL ld_half_lo_signed got=%h exp=ffff8044", t_rdata); end
    transact(1'b1, 32'h0001_000A, 2'b01, 1'b0, 32'h1234_BEEF);
    checks++; if (t_be !== 4'b1100) begin failures++; $display("FAIL st_half_be got=%b exp=1100", t_be); end
    checks++; if (mem[2] !== 32'hBEEF_8044) begin failures++; $display("FAIL st_half_mem got=%h exp=beef8044", mem[2]); end
    transact(1'b0, 32'h0001_000A, 2'b01, 1'b1, 32'd0);
    checks++; if (t_rdata !== 32'h0000_BEEF) begin failures++; $display("FAIL ld_half_hi_unsigned got=%h exp=0000beef", t_rdata); end
    transact(1'b0, 32'h0001_000B, 2'b00, 1'b0, 32'd0);
    checks++; if (t_rdata !== 32'hFFFF_FFBE) begin failures++; $display("FAIL ld_byte3_signed got=%h exp=ffffffbe", t_rdata); end
  endtask

  task automatic test_errors;
    transact(1'b0, 32'h0001_000B, 2'b01, 1'b0, 32'd0);
    checks++; if (t_err !== 1'b1 || t_rdata !== 32'd0) begin failures++; $display("FAIL err_half_misalign err=%b rdata=%h exp 1/0", t_err, t_rdata); end
    checks++; if (t_lat !== 0 || t_wren !== 1'b0) begin failures++; $display("FAIL err_half_timing lat=%0d wren=%b exp 0/0", t_lat, t_wren); end
    transact(1'b0, 32'h0003_0000, 2'b10, 1'b0, 32'd0);
    checks++; if (t_err !== 1'b1) begin failures++; $display("FAIL err_above_range err=%b exp=1", t_err); end
    transact(1'b0, 32'h0000_FFFC, 2'b10, 1'b0, 32'd0);
    checks++; if (t_err !== 1'b1) begin failures++; $display("FAIL err_below_base err=%b exp=1", t_err); end
    transact(1'b0, 32'h0001_0008, 2'b11, 1'b0, 32'd0);
    checks++; if (t_err !== 1'b1) begin failures++; $display("FAIL err_size11 err=%b exp=1", t_err); end
    transact(1'b1, 32'h0001_0006, 2'b10, 1'b0, 32'h5555_5555);
    checks++; if (t_err !== 1'b1 || t_wren !== 1'b0) begin failures++; $display("FAIL err_store_misalign err=%b wren=%b exp 1/0", t_err, t_wren); end
    transact(1'b1, 32'h0002_FFFC, 2'b10, 1'b0, 32'h5A5A_1234);
    checks++; if (t_err !== 1'b0 || mem[32767] !== 32'h5A5A_1234) begin failures++; $display("FAIL last_word_store err=%b mem=%h exp 0/5a5a1234", t_err, mem[32767]); end
    transact(1'b0, 32'h0002_FFFC, 2'b10, 1'b0, 32'd0);
    checks++; if (t_err !== 1'b0 || t_rdata !== 32'h5A5A_1234) begin failures++; $display("FAIL last_word_load err=%b rdata=%h exp 0/5a5a1234", t_err, t_rdata); end
  endtask

  task automatic test_backpressure;
    @(negedge clock);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0001_0008; req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hBEEF_8044 || req_ready !== 1'b0) begin failures++; $display("FAIL bp_hold cyc=%0d rsp_valid=%b rdata=%h req_ready=%b exp 1/beef8044/0", i, rsp_valid, rsp_rdata, req_ready); end
      @(posedge clock); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_handoff rsp_valid=%b req_ready=%b exp 0/1", rsp_valid, req_ready); end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc;
    int rsp;
    acc = 0; rsp = 0;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0001_0008; req_size = 2'b10;
    rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (req_ready) acc++;
      if (rsp_valid) rsp++;
      @(posedge clock);
      @(negedge clock);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++; if (acc !== 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", acc); end
    checks++; if (rsp !== 3) begin failures++; $display("FAIL b2b_responses got=%0d exp=3", rsp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    clock = 1'b0; resetn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b0;
    t_rdata = 32'd0; t_err = 1'b0; t_wren = 1'b0; t_be = 4'b0000; t_lat = 0;
    test_reset;
    test_reset_abort;
    test_word;
    test_subword;
    test_errors;
    test_backpressure;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
